// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      RESP  = 2'd2,
      BURST = 2'd3
   } state_e;

   localparam int BURST_LEN  = 4;
   localparam int WORD_BYTES = 2;

   // Latency counter width: ceil(log2(latency)), never below one bit.
   function automatic int cnt_width(input int latency);
      return (latency <= 2) ? 1 : $clog2(latency);
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word storage: synchronous write, registered read.
// A write clears the read register so a write acknowledge carries zero data.
module mem_resp_array #(
   parameter int DATA_W = 16,
   parameter int MEM_AW = 13
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [MEM_AW-1:0] idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<MEM_AW)-1];
   logic [DATA_W-1:0] rdata_q;

   // Storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   // Read register holds its value until the next access.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= {DATA_W{1'b0}};
      end else if (we_i) begin
         rdata_q <= {DATA_W{1'b0}};
      end else if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end else begin
         rdata_q <= rdata_q;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_resp_mc.sv
// Multi-cycle data-memory responder with fixed access latency and valid/ready requests.
// Optional wrapping 4-beat read bursts are enabled by defining MEM_BURST_EN.
module mem_resp_mc
   import mem_resp_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int MEM_AW  = 13,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
`ifdef MEM_BURST_EN
   input  logic              req_burst,
   output logic              resp_last,
`endif
   output logic              busy
);

   localparam int            CW       = cnt_width(LATENCY);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic                wr_q;
   logic [MEM_AW-1:0]   idx_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic                busy_q;

   logic                accept_s;
   logic                access_s;
   logic                arr_we_s;
   logic                arr_re_s;
   logic [MEM_AW-1:0]   arr_idx_s;
   logic                unused_addr_s;

`ifdef MEM_BURST_EN
   localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

   logic                burst_q;
   logic [1:0]          beat_q;
   logic                resp_last_q;
   logic [1:0]          beat_nxt_s;
   logic [1:0]          wrap_s;
`endif

   assign accept_s      = req_valid & req_ready_q;
   assign access_s      = (state_q == WAIT) && (cnt_q == {CW{1'b0}});
   assign unused_addr_s = ^{req_addr[ADDR_W-1:MEM_AW+1], req_addr[0]};

   // Array control: the single access, plus follow-on burst beats fetched one cycle ahead.
   always_comb begin
      arr_we_s  = access_s & wr_q;
      arr_re_s  = access_s & ~wr_q;
      arr_idx_s = idx_q;
`ifdef MEM_BURST_EN
      beat_nxt_s = beat_q + 2'd1;
      wrap_s     = idx_q[1:0] + beat_nxt_s;
      if (((state_q == RESP) && burst_q) ||
          ((state_q == BURST) && (beat_q != LAST_BEAT))) begin
         arr_re_s  = 1'b1;
         arr_idx_s = {idx_q[MEM_AW-1:2], wrap_s};
      end else begin
         arr_idx_s = idx_q;
      end
`endif
   end

   mem_resp_array #(
      .DATA_W (DATA_W),
      .MEM_AW (MEM_AW)
   ) u_array (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (arr_we_s),
      .re_i    (arr_re_s),
      .idx_i   (arr_idx_s),
      .wdata_i (wdata_q),
      .rdata_o (resp_rdata)
   );

   // Request FSM with registered handshake and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= {CW{1'b0}};
         wr_q         <= 1'b0;
         idx_q        <= {MEM_AW{1'b0}};
         wdata_q      <= {DATA_W{1'b0}};
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef MEM_BURST_EN
         burst_q      <= 1'b0;
         beat_q       <= 2'd0;
         resp_last_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               resp_valid_q <= 1'b0;
               if (accept_s) begin
                  wr_q        <= req_wr;
                  idx_q       <= req_addr[MEM_AW:1];
                  wdata_q     <= req_wdata;
                  cnt_q       <= CNT_LOAD;
                  state_q     <= WAIT;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
`ifdef MEM_BURST_EN
                  burst_q     <= req_burst & ~req_wr;
`endif
               end
            end
            WAIT: begin
               if (cnt_q == {CW{1'b0}}) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
`ifdef MEM_BURST_EN
                  beat_q       <= 2'd0;
                  resp_last_q  <= ~burst_q;
`endif
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            RESP: begin
`ifdef MEM_BURST_EN
               if (burst_q) begin
                  state_q     <= BURST;
                  beat_q      <= 2'd1;
                  resp_last_q <= 1'b0;
               end else begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_last_q  <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end
`else
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
`endif
            end
`ifdef MEM_BURST_EN
            BURST: begin
               if (beat_q == LAST_BEAT) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_last_q  <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  beat_q      <= beat_q + 2'd1;
                  resp_last_q <= (beat_q == (LAST_BEAT - 2'd1));
               end
            end
`endif
            default: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign busy       = busy_q;
`ifdef MEM_BURST_EN
   assign resp_last  = resp_last_q;
`endif

endmodule

// File: tb/tb_mem_resp_mc.sv
// Directed, table-driven bench for mem_resp_mc (LATENCY=4), with extra burst
// checks when MEM_BURST_EN is defined.
module tb_mem_resp_mc;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        busy;
`ifdef MEM_BURST_EN
   logic        req_burst;
   logic        resp_last;
`endif

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   mem_resp_mc #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .MEM_AW  (13),
      .LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
`ifdef MEM_BURST_EN
      .req_burst  (req_burst),
      .resp_last  (resp_last),
`endif
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete single-beat transaction with cycle-exact checks.
   task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp, input string tag);
      @(negedge clk);
      chk({tag, "_ready_idle"}, 16'(req_ready), 16'd1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wr    = ~wr;
      req_addr  = addr ^ 16'h0006;
      req_wdata = ~wdata;
      chk({tag, "_ready_low"}, 16'(req_ready), 16'd0);
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      for (int c = 1; c < LAT; c++) begin
         @(posedge clk); #1;
         chk({tag, "_no_early_resp"}, 16'(resp_valid), 16'd0);
      end
      @(posedge clk); #1;
      chk({tag, "_resp_valid"}, 16'(resp_valid), 16'd1);
      chk({tag, "_rdata"}, resp_rdata, exp);
`ifdef MEM_BURST_EN
      chk({tag, "_last"}, 16'(resp_last), 16'd1);
`endif
      @(posedge clk); #1;
      chk({tag, "_resp_drop"}, 16'(resp_valid), 16'd0);
      chk({tag, "_busy_drop"}, 16'(busy), 16'd0);
      chk({tag, "_ready_back"}, 16'(req_ready), 16'd1);
   endtask

   initial begin
      int pulses;
      logic [15:0] bexp [4];

      vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF};
      vecs[3] = '{1'b0, 16'h4010, 16'h0000, 16'hBEEF};
      vecs[4] = '{1'b1, 16'h0020, 16'h1234, 16'h0000};
      vecs[5] = '{1'b1, 16'h3FFE, 16'hA5A5, 16'h0000};
      vecs[6] = '{1'b0, 16'hFFFE, 16'h0000, 16'hA5A5};
      vecs[7] = '{1'b0, 16'h0020, 16'h0000, 16'h1234};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 16'h0000;
`ifdef MEM_BURST_EN
      req_burst = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 16'(req_ready), 16'd1);
      chk("rst_resp_valid", 16'(resp_valid), 16'd0);
      chk("rst_rdata", resp_rdata, 16'h0000);
      chk("rst_busy", 16'(busy), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Reset two cycles into a write must drop it before the commit edge.
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'h5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_resp_valid", 16'(resp_valid), 16'd0);
      chk("midrst_busy", 16'(busy), 16'd0);
      chk("midrst_ready", 16'(req_ready), 16'd1);
      pulses = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (resp_valid) pulses++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (resp_valid) pulses++;
      end
      chk("midrst_no_pulse", 16'(pulses), 16'd0);
      txn(1'b0, 16'h0020, 16'h0000, 16'h1234, "after_rst_read");

      // Held req_valid: read then write to the same word, second accepted after RESP.
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h0020;
      req_wdata = 16'h0000;
      @(posedge clk); #1;
      req_wr    = 1'b1;
      req_wdata = 16'h9999;
      pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (resp_valid) pulses++;
         if (k < LAT) chk("b2b_ready_wait", 16'(req_ready), 16'd0);
         if (k == LAT) begin
            chk("b2b_first_valid", 16'(resp_valid), 16'd1);
            chk("b2b_first_old_data", resp_rdata, 16'h1234);
            chk("b2b_no_accept_in_resp", 16'(req_ready), 16'd0);
         end
         if (k == LAT + 1) chk("b2b_idle_ready", 16'(req_ready), 16'd1);
         if (k == LAT + 2) begin
            chk("b2b_second_accepted", 16'(req_ready), 16'd0);
            chk("b2b_second_busy", 16'(busy), 16'd1);
            req_valid = 1'b0;
         end
         if (k == 2 * LAT + 2) begin
            chk("b2b_second_valid", 16'(resp_valid), 16'd1);
            chk("b2b_second_ack_zero", resp_rdata, 16'h0000);
         end
      end
      chk("b2b_pulse_count", 16'(pulses), 16'd2);
      txn(1'b0, 16'h0020, 16'h0000, 16'h9999, "b2b_new_value");

`ifdef MEM_BURST_EN
      txn(1'b1, 16'h0020, 16'h0001, 16'h0000, "bw0");
      txn(1'b1, 16'h0022, 16'h0002, 16'h0000, "bw1");
      txn(1'b1, 16'h0024, 16'h0003, 16'h0000, "bw2");
      txn(1'b1, 16'h0026, 16'h0004, 16'h0000, "bw3");
      bexp[0] = 16'h0003;
      bexp[1] = 16'h0004;
      bexp[2] = 16'h0001;
      bexp[3] = 16'h0002;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h0024;
      req_burst = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_burst = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         chk($sformatf("burst%0d_valid", b), 16'(resp_valid), 16'd1);
         chk($sformatf("burst%0d_data", b), resp_rdata, bexp[b]);
         chk($sformatf("burst%0d_last", b), 16'(resp_last), (b == 3) ? 16'd1 : 16'd0);
         chk($sformatf("burst%0d_busy", b), 16'(busy), 16'd1);
      end
      @(posedge clk); #1;
      chk("burst_end_valid", 16'(resp_valid), 16'd0);
      chk("burst_end_busy", 16'(busy), 16'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
